// File: rtl/kernel_axis_packetizer.sv
// Buffers axis00 result beats in a small FIFO and re-frames them into fixed-length
// packets, with an ap_start/ap_done/ap_idle run protocol matching the kernel top.
module kernel_axis_packetizer #(
  parameter int unsigned C_TDATA_WIDTH     = 512,
  parameter int unsigned C_FIFO_DEPTH      = 16,
  parameter int unsigned C_PKT_BEATS_WIDTH = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  input  logic [C_PKT_BEATS_WIDTH-1:0] ctrl_pkt_beats,
  input  logic [31:0]                  ctrl_total_beats,
  output logic                         ap_idle,
  output logic                         ap_done,
  output logic [31:0]                  pkt_count,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [C_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                         s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                         m_axis_tlast
);

  localparam int unsigned KEEP_W  = C_TDATA_WIDTH / 8;
  localparam int unsigned ENTRY_W = C_TDATA_WIDTH + KEEP_W + 1;
  localparam int unsigned PTR_W   = $clog2(C_FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [C_PKT_BEATS_WIDTH-1:0] pkt_beats_q, pkt_beats_d;
  logic [31:0]                  total_q, total_d;
  logic [31:0]                  in_cnt_q, in_cnt_d;
  logic [31:0]                  out_cnt_q, out_cnt_d;
  logic [C_PKT_BEATS_WIDTH-1:0] beat_in_pkt_q, beat_in_pkt_d;
  logic [31:0]                  pkt_count_q, pkt_count_d;
  logic                         ap_idle_q;
  logic                         ap_done_q;

  logic [ENTRY_W-1:0]           mem_q [C_FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [ENTRY_W-1:0]           head;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head_last;

  assign fifo_full  = (count_q == CNT_W'(C_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_last  = head[ENTRY_W-1];

  // Ready depends only on registered state, never on the downstream ready.
  always_comb begin
    s_axis_tready = (state_q == S_RUN) && !fifo_full && (in_cnt_q < total_q);
    m_axis_tvalid = !fifo_empty;
    m_axis_tdata  = head[C_TDATA_WIDTH-1:0];
    m_axis_tkeep  = head[C_TDATA_WIDTH +: KEEP_W];
    m_axis_tlast  = !fifo_empty &&
                    ((beat_in_pkt_q == pkt_beats_q - C_PKT_BEATS_WIDTH'(1)) ||
                     (out_cnt_q == total_q - 32'd1) ||
                     head_last);
  end

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pkt_beats_d   = pkt_beats_q;
    total_d       = total_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    beat_in_pkt_d = beat_in_pkt_q;
    pkt_count_d   = pkt_count_q;

    if (push) in_cnt_d = in_cnt_q + 32'd1;
    if (pop) begin
      out_cnt_d = out_cnt_q + 32'd1;
      if (m_axis_tlast) begin
        beat_in_pkt_d = '0;
        pkt_count_d   = pkt_count_q + 32'd1;
      end else begin
        beat_in_pkt_d = beat_in_pkt_q + C_PKT_BEATS_WIDTH'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          // A zero packet length would never raise tlast; run it as one beat per packet.
          pkt_beats_d   = (ctrl_pkt_beats == '0) ? C_PKT_BEATS_WIDTH'(1) : ctrl_pkt_beats;
          total_d       = ctrl_total_beats;
          in_cnt_d      = '0;
          out_cnt_d     = '0;
          beat_in_pkt_d = '0;
          pkt_count_d   = '0;
          state_d       = S_RUN;
        end
      end
      S_RUN: begin
        if (out_cnt_q == total_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= S_IDLE;
      pkt_beats_q   <= C_PKT_BEATS_WIDTH'(1);
      total_q       <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      beat_in_pkt_q <= '0;
      pkt_count_q   <= '0;
      ap_idle_q     <= 1'b1;
      ap_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pkt_beats_q   <= pkt_beats_d;
      total_q       <= total_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      beat_in_pkt_q <= beat_in_pkt_d;
      pkt_count_q   <= pkt_count_d;
      ap_idle_q     <= (state_d == S_IDLE);
      ap_done_q     <= (state_d == S_DONE);
    end
  end

  assign ap_idle   = ap_idle_q;
  assign ap_done   = ap_done_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_kernel_axis_packetizer.sv
// Directed bench for kernel_axis_packetizer: scoreboard of expected output beats
// built from the stimulus, with packet framing modelled independently.
module tb_kernel_axis_packetizer;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          ap_start;
  logic [7:0]    ctrl_pkt_beats;
  logic [31:0]   ctrl_total_beats;
  logic          ap_idle;
  logic          ap_done;
  logic [31:0]   pkt_count;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;

  kernel_axis_packetizer #(
    .C_TDATA_WIDTH     (DW),
    .C_FIFO_DEPTH      (16),
    .C_PKT_BEATS_WIDTH (8)
  ) dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .ap_start         (ap_start),
    .ctrl_pkt_beats   (ctrl_pkt_beats),
    .ctrl_total_beats (ctrl_total_beats),
    .ap_idle          (ap_idle),
    .ap_done          (ap_done),
    .pkt_count        (pkt_count),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          beat_no  = 0;
  int unsigned in_acc   = 0;
  int unsigned m_pb     = 1;
  int unsigned m_bip    = 0;
  beat_t       exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int r, input int unsigned i);
    logic [DW-1:0] d;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = {r[7:0], j[7:0], i[15:0]};
    return d;
  endfunction

  function automatic logic [KW-1:0] mk_keep(input int r, input int unsigned i);
    logic [31:0] a;
    logic [31:0] b;
    a = i * 32'd7 + r;
    b = ~i;
    return {a, b};
  endfunction

  // Output monitor: every downstream handshake pops and compares one expected beat.
  always @(negedge ap_clk) begin
    beat_t o;
    beat_t e;
    if (ap_done) done_cnt++;
    if (ap_rst_n && m_axis_tvalid && m_axis_tready) begin
      o = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (exp_q.size() == 0) begin
        check("unexpected_out_beat", 64'(m_axis_tvalid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checks++;
        assert (o === e) else begin
          failures++;
          $error("FAIL out_beat%0d: observed last=%0b keep=%h data_lo=%h expected last=%0b keep=%h data_lo=%h",
                 beat_no, o.l, o.k, o.d[63:0], e.l, e.k, e.d[63:0]);
        end
      end
      beat_no++;
    end
  end

  task automatic start_run(input int unsigned pb, input int unsigned tot);
    ctrl_pkt_beats   = 8'(pb);
    ctrl_total_beats = tot;
    ap_start         = 1'b1;
    m_pb             = (pb == 0) ? 1 : pb;
    m_bip            = 0;
    in_acc           = 0;
    @(posedge ap_clk); #1;
    ap_start         = 1'b0;
  endtask

  task automatic feed(input int r, input int unsigned n, input int unsigned tot, input int ulast);
    beat_t e;
    int    waited;
    for (int unsigned i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_data(r, i);
      s_axis_tkeep  = mk_keep(r, i);
      s_axis_tlast  = (int'(i) == ulast);
      waited = 0;
      @(negedge ap_clk);
      while (!s_axis_tready && waited < 300) begin
        @(negedge ap_clk);
        waited++;
      end
      if (!s_axis_tready) begin
        check("in_handshake_timeout", 64'(s_axis_tready), 64'd1);
        break;
      end
      e.d = mk_data(r, i);
      e.k = mk_keep(r, i);
      e.l = (m_bip == m_pb - 1) || (i == tot - 1) || (int'(i) == ulast);
      m_bip = e.l ? 0 : m_bip + 1;
      exp_q.push_back(e);
      in_acc++;
      @(posedge ap_clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int done_before, input int unsigned exp_pkts);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!ap_done && n < 500) begin
      @(negedge ap_clk);
      n++;
    end
    check({tag, "_done"}, 64'(ap_done), 64'd1);
    check({tag, "_idle_low_in_done"}, 64'(ap_idle), 64'd0);
    @(negedge ap_clk);
    check({tag, "_done_one_cycle"}, 64'(ap_done), 64'd0);
    check({tag, "_idle_after"}, 64'(ap_idle), 64'd1);
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts));
    check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt - done_before), 64'd1);
  endtask

  initial begin
    int          d0;
    logic [DW-1:0] snap_d;
    logic [KW-1:0] snap_k;
    logic          snap_l;
    logic          stable;

    ap_rst_n = 1'b0; ap_start = 1'b0; ctrl_pkt_beats = '0; ctrl_total_beats = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_done", 64'(ap_done), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Packets of 4 over 12 beats.
    d0 = done_cnt;
    start_run(4, 12);
    feed(1, 12, 12, -1);
    finish_run("t1", d0, 3);

    // Short final packet.
    d0 = done_cnt;
    start_run(4, 10);
    feed(2, 10, 10, -1);
    finish_run("t2", d0, 3);

    // Downstream stall fills the FIFO; outputs must hold.
    m_axis_tready = 1'b0;
    d0 = done_cnt;
    start_run(8, 32);
    fork
      feed(3, 32, 32, -1);
      begin
        repeat (30) @(negedge ap_clk);
        snap_d = m_axis_tdata; snap_k = m_axis_tkeep; snap_l = m_axis_tlast;
        stable = 1'b1;
        repeat (10) begin
          @(negedge ap_clk);
          if (m_axis_tdata !== snap_d || m_axis_tkeep !== snap_k || m_axis_tlast !== snap_l)
            stable = 1'b0;
        end
        check("t3_accepted_while_stalled", 64'(in_acc), 64'd16);
        check("t3_s_tready_full", 64'(s_axis_tready), 64'd0);
        check("t3_m_tvalid_stalled", 64'(m_axis_tvalid), 64'd1);
        check("t3_outputs_stable", 64'(stable), 64'd1);
        check("t3_head_data", snap_d[63:0], mk_data(3, 0) >> 0);
        @(posedge ap_clk); #1;
        m_axis_tready = 1'b1;
      end
    join
    finish_run("t3", d0, 4);

    // Upstream tlast forces an early packet boundary.
    d0 = done_cnt;
    start_run(8, 8);
    feed(4, 8, 8, 2);
    finish_run("t4", d0, 2);

    // Zero-length run; a start pulse during RUN must be ignored.
    d0 = done_cnt;
    start_run(4, 0);
    ap_start = 1'b1;
    ctrl_total_beats = 32'd5;
    @(negedge ap_clk);
    check("t5_run_done_low", 64'(ap_done), 64'd0);
    check("t5_run_idle_low", 64'(ap_idle), 64'd0);
    check("t5_no_s_tready", 64'(s_axis_tready), 64'd0);
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    @(negedge ap_clk);
    check("t5_done_two_cycles", 64'(ap_done), 64'd1);
    check("t5_no_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t5_pkt_count", 64'(pkt_count), 64'd0);
    repeat (3) @(negedge ap_clk);
    check("t5_idle_after", 64'(ap_idle), 64'd1);
    check("t5_restart_ignored", 64'(s_axis_tready), 64'd0);
    check("t5_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of a run with data buffered.
    m_axis_tready = 1'b0;
    start_run(4, 20);
    feed(5, 5, 20, -1);
    check("t6_pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    check("t6_rst_idle", 64'(ap_idle), 64'd1);
    check("t6_rst_done", 64'(ap_done), 64'd0);
    check("t6_rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("t6_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("t6_rst_pkt_count", 64'(pkt_count), 64'd0);
    exp_q.delete();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge ap_clk); #1;
    d0 = done_cnt;
    start_run(2, 4);
    feed(6, 4, 4, -1);
    finish_run("t6", d0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kernel_axis_packetizer.md
Name: kernel_axis_packetizer

Overview:
Downstream stage for the kernel's axis00 output stream (512-bit AXI4-Stream vadd results). It buffers result beats in a small FIFO and re-frames them into fixed-length packets for the NetFPGA datapath, inserting tlast every PKT_BEATS beats and on the final beat of a run. It is started and completed with the same ap_start/ap_done/ap_idle pulse protocol as the kernel top.

Parameters:
C_TDATA_WIDTH, 512, stream data width in bits; tkeep width is C_TDATA_WIDTH/8.
C_FIFO_DEPTH, 16, FIFO entries; power of 2, at least 4.
C_PKT_BEATS_WIDTH, 8, width of the packet-length control input.

Ports:
ap_clk  in  1  clock; all logic on rising edge.
ap_rst_n  in  1  asynchronous, active-low reset.
ap_start  in  1  single-cycle start pulse.
ctrl_pkt_beats  in  C_PKT_BEATS_WIDTH  beats per packet; sampled on accepted start.
ctrl_total_beats  in  32  beats to move this run; sampled on accepted start.
ap_idle  out  1  high in IDLE.
ap_done  out  1  one-cycle pulse at run completion.
pkt_count  out  32  packets emitted in current or last run.
s_axis_tvalid  in  1  upstream valid (kernel axis00).
s_axis_tready  out  1  upstream ready.
s_axis_tdata  in  C_TDATA_WIDTH  upstream data.
s_axis_tkeep  in  C_TDATA_WIDTH/8  upstream byte enables.
s_axis_tlast  in  1  upstream last.
m_axis_tvalid  out  1  downstream valid.
m_axis_tready  in  1  downstream ready.
m_axis_tdata  out  C_TDATA_WIDTH  downstream data.
m_axis_tkeep  out  C_TDATA_WIDTH/8  downstream byte enables.
m_axis_tlast  out  1  packet boundary.

Behaviour:
- Reset (async assert, sync deassert is external): state=IDLE; FIFO pointers, in_cnt, out_cnt, beat_in_pkt and pkt_count cleared; ap_idle=1; ap_done=0; s_axis_tready=0; m_axis_tvalid=0; m_axis_tlast=0. Reset mid-run discards all buffered data; no partial packet is completed.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on ap_start=1, latch pkt_beats_r (0 is treated as 1) and total_r, clear the counters and pkt_count, then go to RUN. ap_start is ignored in RUN and DONE.
  - RUN: when out_cnt==total_r, go to DONE. If total_r==0, go to DONE on the first RUN cycle.
  - DONE: ap_done=1 for exactly one cycle, then return to IDLE. ap_idle is low from the cycle after start until the cycle after the ap_done pulse.
- Input side:
  - s_axis_tready = (state==RUN) && !fifo_full && (in_cnt < total_r). It is registered-only logic with no combinational path from m_axis_tready.
  - On handshake, write {tdata, tkeep, tlast} to the FIFO and increment in_cnt. Beats beyond total_r are not accepted.
- FIFO:
  - Write when full is impossible because tready is low. A push and a pop in the same cycle are allowed when neither full nor empty blocks them, and occupancy is unchanged.
  - full = count==C_FIFO_DEPTH; empty = count==0. Pointers wrap modulo C_FIFO_DEPTH.
- Output side:
  - m_axis_tvalid = !empty; data and keep come from the FIFO head.
  - Latency: a beat accepted on cycle N is valid on m_axis at cycle N+1 when the FIFO was empty.
  - While tvalid && !tready, tdata, tkeep and tlast hold stable.
  - m_axis_tlast = (beat_in_pkt == pkt_beats_r-1) || (out_cnt == total_r-1) || stored s_axis_tlast.
  - On output handshake: out_cnt++. If tlast, beat_in_pkt resets to 0 and pkt_count++; otherwise beat_in_pkt++.
- pkt_count holds its value after DONE until the next accepted start.
- Arithmetic: the counters are 32-bit and total_r ≤ 2^32-1, so no wrap occurs within a run. beat_in_pkt is C_PKT_BEATS_WIDTH bits wide.

Test Plan:
1. pkt_beats=4, total=12, upstream always valid, downstream always ready -> 12 beats out, tlast on beats 3, 7 and 11, pkt_count=3, a single ap_done pulse, data order preserved.
2. pkt_beats=4, total=10 -> tlast on beats 3, 7 and 9 (short final packet), pkt_count=3.
3. m_axis_tready held low for 40 cycles with total=32 -> exactly 16 beats accepted, then s_axis_tready=0, m_axis outputs stable. After release, all 32 beats are delivered with no loss or duplication.
4. Upstream tlast on beat 2 with pkt_beats=8, total=8 -> tlast on beats 2 and 7, pkt_count=2.
5. total=0 -> no s_axis_tready, no m_axis_tvalid, ap_done two cycles after start, pkt_count=0. A second ap_start pulse during RUN of another run is ignored.
6. ap_rst_n asserted after 5 of 20 beats -> all outputs reach reset values immediately. A following run with pkt_beats=2, total=4 completes normally with pkt_count=2.
